alsu_core: RTL and testbench

Registered 3-bit arithmetic/logic/shift unit that sits directly upstream of the seven-segment display controller and produces its `result[5:0]` and `invalid` inputs. Operands and controls are captured in an input register stage, and the operation result is written to an output register. Shift and rotate operate on the current output register contents. A 16-bit LED bank blinks while the registered result is invalid.

---
 rtl/alsu_pkg.sv | 36 +++
 rtl/led_blinker.sv | 40 ++++
 rtl/alsu_core.sv | 131 +++++++++++++
 tb/tb_alsu_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared definitions for the registered arithmetic/logic/shift unit:
// operand/result widths, opcode encodings and the stage-1 capture record.
package alsu_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 6;
    localparam int LED_W  = 16;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_ROT   = 3'b101;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [2:0]        opcode;
        logic              cin;
        logic              serial_in;
        logic              direction;
        logic              red_op_a;
        logic              red_op_b;
        logic              bypass_a;
        logic              bypass_b;
    } stage1_t;

    localparam int S1_W = $bits(stage1_t);

    // Operand B wins when only its flag is set, or when both are set and B has priority.
    function automatic logic pick_b(input logic flag_a, input logic flag_b, input logic prio_b);
        return flag_b & (~flag_a | prio_b);
    endfunction

endpackage

// File: rtl/led_blinker.sv
// Blink divider: while en is high the LED bank alternates all-on/all-off every
// BLINK_DIV cycles, starting all-on; dropping en blanks the bank and clears the divider.
module led_blinker
    import alsu_pkg::*;
#(
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [LED_W-1:0] leds
);

    localparam int              CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             dark_r;

    // Divider and phase toggle; both held clear whenever the unit is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            dark_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= {CNT_W{1'b0}};
            dark_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= {CNT_W{1'b0}};
            dark_r <= ~dark_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            dark_r <= dark_r;
        end
    end

    // Gated by the registered en so the bank lights on the very cycle invalid rises.
    assign leds = (en && !dark_r) ? {LED_W{1'b1}} : {LED_W{1'b0}};

endmodule

// File: rtl/alsu_core.sv
// Two-stage arithmetic/logic/shift unit: inputs captured in stage 1, decoded
// result and invalid flag registered in stage 2; shift/rotate act on the held result.
module alsu_core
    import alsu_pkg::*;
#(
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_DIV      = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    input  logic [2:0]        opcode,
    input  logic              cin,
    input  logic              serial_in,
    input  logic              direction,
    input  logic              red_op_A,
    input  logic              red_op_B,
    input  logic              bypass_A,
    input  logic              bypass_B,
    output logic [RES_W-1:0]  result,
    output logic              invalid,
    output logic [LED_W-1:0]  leds
);

    localparam logic PRIO_B_C = (INPUT_PRIORITY == "B") ? 1'b1 : 1'b0;
    localparam logic FA_ON_C  = (FULL_ADDER == "ON") ? 1'b1 : 1'b0;

    stage1_t          s1_r;
    stage1_t          s1_next_s;
    logic [RES_W-1:0] result_r;
    logic [RES_W-1:0] result_next_s;
    logic             invalid_r;
    logic             invalid_next_s;
    logic             red_any_s;
    logic             op_illegal_s;
    logic [OPND_W-1:0] red_opnd_s;

    assign s1_next_s = {A, B, opcode, cin, serial_in, direction,
                        red_op_A, red_op_B, bypass_A, bypass_B};

    // Stage 1: capture every input each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= stage1_t'({S1_W{1'b0}});
        end else begin
            s1_r <= s1_next_s;
        end
    end

    assign red_any_s    = s1_r.red_op_a | s1_r.red_op_b;
    assign op_illegal_s = (s1_r.opcode == 3'b110) || (s1_r.opcode == 3'b111) ||
                          (red_any_s && (s1_r.opcode != OP_AND) && (s1_r.opcode != OP_XOR));
    assign red_opnd_s   = pick_b(s1_r.red_op_a, s1_r.red_op_b, PRIO_B_C) ? s1_r.b : s1_r.a;

    // Stage 2 decode: bypass, then illegal combinations, then the opcode datapath.
    always_comb begin
        result_next_s  = {RES_W{1'b0}};
        invalid_next_s = 1'b0;
        if (s1_r.bypass_a || s1_r.bypass_b) begin
            if (pick_b(s1_r.bypass_a, s1_r.bypass_b, PRIO_B_C)) begin
                result_next_s = {3'b000, s1_r.b};
            end else begin
                result_next_s = {3'b000, s1_r.a};
            end
        end else if (op_illegal_s) begin
            invalid_next_s = 1'b1;
            result_next_s  = {RES_W{1'b0}};
        end else begin
            case (s1_r.opcode)
                OP_AND: begin
                    if (red_any_s) begin
                        result_next_s = {5'b00000, &red_opnd_s};
                    end else begin
                        result_next_s = {3'b000, s1_r.a & s1_r.b};
                    end
                end
                OP_XOR: begin
                    if (red_any_s) begin
                        result_next_s = {5'b00000, ^red_opnd_s};
                    end else begin
                        result_next_s = {3'b000, s1_r.a ^ s1_r.b};
                    end
                end
                OP_ADD:   result_next_s = {3'b000, s1_r.a} + {3'b000, s1_r.b} +
                                          {5'b00000, s1_r.cin & FA_ON_C};
                OP_MUL:   result_next_s = {3'b000, s1_r.a} * {3'b000, s1_r.b};
                OP_SHIFT: begin
                    if (s1_r.direction) begin
                        result_next_s = {result_r[4:0], s1_r.serial_in};
                    end else begin
                        result_next_s = {s1_r.serial_in, result_r[5:1]};
                    end
                end
                OP_ROT: begin
                    if (s1_r.direction) begin
                        result_next_s = {result_r[4:0], result_r[5]};
                    end else begin
                        result_next_s = {result_r[0], result_r[5:1]};
                    end
                end
                default: result_next_s = {RES_W{1'b0}};
            endcase
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r  <= {RES_W{1'b0}};
            invalid_r <= 1'b0;
        end else begin
            result_r  <= result_next_s;
            invalid_r <= invalid_next_s;
        end
    end

    assign result  = result_r;
    assign invalid = invalid_r;

    led_blinker #(
        .BLINK_DIV(BLINK_DIV)
    ) u_led_blinker (
        .clk (clk),
        .rst (rst),
        .en  (invalid_r),
        .leds(leds)
    );

endmodule

// File: tb/tb_alsu_core.sv
// Randomised self-checking bench for alsu_core: two configurations driven in
// parallel and compared every cycle against an arithmetic reference model.
module tb_alsu_core;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] op;
        logic       cin;
        logic       sin;
        logic       dir;
        logic       ra;
        logic       rb;
        logic       ba;
        logic       bb;
    } in_t;

    logic        clk;
    logic        rst;
    logic [2:0]  a, b, opcode;
    logic        cin, serial_in, direction, red_op_a, red_op_b, bypass_a, bypass_b;
    logic [5:0]  result_on, result_off;
    logic        invalid_on, invalid_off;
    logic [15:0] leds_on, leds_off;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    in_t st;
    int  mr_on, mr_off, k_on, k_off;
    bit  mi_on, mi_off;
    int  tmp_r;
    bit  tmp_i;

    alsu_core #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .BLINK_DIV(4)) dut_on (
        .clk(clk), .rst(rst), .A(a), .B(b), .opcode(opcode), .cin(cin),
        .serial_in(serial_in), .direction(direction), .red_op_A(red_op_a),
        .red_op_B(red_op_b), .bypass_A(bypass_a), .bypass_B(bypass_b),
        .result(result_on), .invalid(invalid_on), .leds(leds_on));

    alsu_core #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .BLINK_DIV(1)) dut_off (
        .clk(clk), .rst(rst), .A(a), .B(b), .opcode(opcode), .cin(cin),
        .serial_in(serial_in), .direction(direction), .red_op_A(red_op_a),
        .red_op_B(red_op_b), .bypass_A(bypass_a), .bypass_B(bypass_b),
        .result(result_off), .invalid(invalid_off), .leds(leds_off));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_op(input in_t s, input int prev, input bit fa, input bit pb,
                                     output int r, output bit inv);
        int ia, ib, x;
        bit useb;
        ia = s.a;
        ib = s.b;
        r = 0;
        inv = 0;
        useb = s.rb && (!s.ra || pb);
        x = useb ? ib : ia;
        if (s.ba || s.bb) begin
            r = (s.bb && (!s.ba || pb)) ? ib : ia;
        end else if (s.op >= 6 || ((s.ra || s.rb) && s.op > 1)) begin
            inv = 1;
        end else begin
            case (s.op)
                3'd0: r = (s.ra || s.rb) ? ((x == 7) ? 1 : 0) : (ia & ib);
                3'd1: r = (s.ra || s.rb) ? ($countones(x) % 2) : (ia ^ ib);
                3'd2: r = ia + ib + ((fa && s.cin) ? 1 : 0);
                3'd3: r = ia * ib;
                3'd4: r = s.dir ? (prev * 2 + s.sin) % 64 : prev / 2 + s.sin * 32;
                3'd5: r = s.dir ? (prev * 2) % 64 + prev / 32 : prev / 2 + (prev % 2) * 32;
                default: r = 0;
            endcase
        end
    endfunction

    function automatic int exp_leds(input bit inv, input int k, input int div);
        if (!inv) return 0;
        return ((k / div) % 2 == 0) ? 32'h0000FFFF : 0;
    endfunction

    // Model advances on the same edge as the DUT, using the inputs held stable across it.
    always @(posedge clk) begin
        if (rst) begin
            st = '0;
            mr_on = 0; mi_on = 0; k_on = 0;
            mr_off = 0; mi_off = 0; k_off = 0;
        end else begin
            model_op(st, mr_on, 1'b1, 1'b0, tmp_r, tmp_i);
            k_on = (tmp_i && mi_on) ? k_on + 1 : 0;
            mr_on = tmp_r; mi_on = tmp_i;
            model_op(st, mr_off, 1'b0, 1'b1, tmp_r, tmp_i);
            k_off = (tmp_i && mi_off) ? k_off + 1 : 0;
            mr_off = tmp_r; mi_off = tmp_i;
            st = {a, b, opcode, cin, serial_in, direction, red_op_a, red_op_b, bypass_a, bypass_b};
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // Hand-computed value checked against both the DUT and the model.
    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] expv);
        chk(name, dut_v, expv);
        chk({"model_", name}, mdl_v, expv);
    endtask

    // Every-cycle comparison, sampled away from the active edge.
    always @(negedge clk) begin
        chk("res_on", {26'd0, result_on}, mr_on);
        chk("inv_on", {31'd0, invalid_on}, {31'd0, mi_on});
        chk("leds_on", {16'd0, leds_on}, exp_leds(mi_on, k_on, 4));
        chk("res_off", {26'd0, result_off}, mr_off);
        chk("inv_off", {31'd0, invalid_off}, {31'd0, mi_off});
        chk("leds_off", {16'd0, leds_off}, exp_leds(mi_off, k_off, 1));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input int ia, input int ib, input int op, input bit c, input bit s,
                          input bit d, input bit ra, input bit rb, input bit ba, input bit bb);
        a = 3'(ia); b = 3'(ib); opcode = 3'(op); cin = c; serial_in = s; direction = d;
        red_op_a = ra; red_op_b = rb; bypass_a = ba; bypass_b = bb;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2);
        lit("rst_res", {26'd0, result_on}, mr_on, 0);
        lit("rst_inv", {31'd0, invalid_on}, {31'd0, mi_on}, 0);
        chk("rst_leds", {16'd0, leds_on}, 0);
        rst = 1'b0;

        set_in(3, 5, 2, 1, 0, 0, 0, 0, 0, 0); step(2);
        lit("add_on", {26'd0, result_on}, mr_on, 9);
        lit("add_off", {26'd0, result_off}, mr_off, 8);
        chk("add_inv", {31'd0, invalid_on}, 0);

        set_in(7, 7, 3, 0, 0, 0, 0, 0, 0, 0); step(2);
        lit("mul", {26'd0, result_on}, mr_on, 49);

        set_in(7, 0, 1, 0, 0, 0, 1, 0, 0, 0); step(2);
        lit("redxor", {26'd0, result_on}, mr_on, 1);
        set_in(7, 0, 2, 0, 0, 0, 1, 0, 0, 0); step(2);
        lit("red_bad_inv", {31'd0, invalid_on}, {31'd0, mi_on}, 1);
        lit("red_bad_res", {26'd0, result_on}, mr_on, 0);

        set_in(5, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(2);
        lit("byp_a", {26'd0, result_on}, mr_on, 5);
        set_in(5, 0, 4, 0, 1, 1, 0, 0, 0, 0); step(1);
        set_in(5, 0, 5, 0, 0, 0, 0, 0, 0, 0); step(1);
        lit("shl", {26'd0, result_on}, mr_on, 6'b001011);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(1);
        lit("rotr", {26'd0, result_on}, mr_on, 6'b100101);

        set_in(0, 0, 6, 0, 0, 0, 0, 0, 0, 0); step(2);
        for (int i = 0; i < 12; i++) begin
            lit($sformatf("blink%0d", i), {16'd0, leds_on}, exp_leds(mi_on, k_on, 4),
                ((i / 4) % 2 == 0) ? 32'h0000FFFF : 32'h0);
            step(1);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(2);
        lit("unblink_inv", {31'd0, invalid_on}, {31'd0, mi_on}, 0);
        lit("unblink_leds", {16'd0, leds_on}, exp_leds(mi_on, k_on, 4), 0);

        set_in(2, 6, 0, 0, 0, 0, 0, 0, 1, 1); step(2);
        lit("prio_a", {26'd0, result_on}, mr_on, 2);
        lit("prio_b", {26'd0, result_off}, mr_off, 6);
        set_in(7, 3, 0, 0, 0, 0, 1, 1, 0, 0); step(2);
        lit("redand_a", {26'd0, result_on}, mr_on, 1);
        lit("redand_b", {26'd0, result_off}, mr_off, 0);

        set_in(5, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(2);
        set_in(5, 0, 4, 0, 1, 0, 0, 0, 0, 0); step(3);
        rst = 1'b1; step(1);
        lit("midrst_res", {26'd0, result_on}, mr_on, 0);
        chk("midrst_inv", {31'd0, invalid_on}, 0);
        chk("midrst_leds", {16'd0, leds_on}, 0);
        rst = 1'b0;
        set_in(0, 0, 4, 0, 1, 1, 0, 0, 0, 0); step(2);
        lit("shl_from0", {26'd0, result_on}, mr_on, 1);
        rst = 1'b1; step(1);
        rst = 1'b0;
        set_in(0, 0, 4, 0, 1, 0, 0, 0, 0, 0); step(2);
        lit("shr_from0", {26'd0, result_on}, mr_on, 32);

        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 60) == 0);
            step(1);
        end
        rst = 1'b1; step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
